// File: rtl/seq_divider_pkg.sv
// Shared ALU constants for the sequential divider: default width, FSM states, step counter width.
package seq_divider_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/seq_divider_addsub.sv
// 4-bit carry-lookahead block and the W-bit add/subtract built from a chain of them.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c[3:0];
  assign co   = c[4];
endmodule

module addsub_16bit #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);
  // Operands are zero-padded past W, so sum bit W is exactly the carry out of bit W-1.
  localparam int NB = (W + 1) / 4 + 1;
  localparam int PW = NB * 4;

  logic [NB-1:0][3:0] ap, bp, sp;
  logic [NB:0]        c;
  logic [PW-1:0]      sum;
  logic               unused_hi;

  assign ap   = PW'(a);
  assign bp   = PW'(b ^ {W{sub}});
  assign c[0] = sub;

  cla4 u_blk [NB-1:0] (
    .a  (ap),
    .b  (bp),
    .ci (c[NB-1:0]),
    .s  (sp),
    .co (c[NB:1])
  );

  assign sum       = sp;
  assign s         = sum[W-1:0];
  assign cout      = sum[W];
  assign unused_hi = ^{sum[PW-1:W+1], c[NB]};
endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, registered results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q, dvs_q, prem;
  logic [WIDTH:0]   shifted, diff;
  logic             no_borrow, last, unused_msb;
  logic [WIDTH-1:0] prem_nxt, quo_nxt;

  // dvd_q shifts left each step; its vacated LSBs collect the quotient bits.
  assign shifted = {prem, dvd_q[WIDTH-1]};

  addsub_16bit #(.W(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs_q}),
    .sub  (1'b1),
    .s    (diff),
    .cout (no_borrow)
  );

  assign prem_nxt   = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt    = {dvd_q[WIDTH-2:0], no_borrow};
  assign last       = (cnt == CW'(WIDTH - 1));
  assign unused_msb = diff[WIDTH];

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
              dvd_q <= dividend;
              dvs_q <= divisor;
              prem  <= '0;
              cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          dvd_q <= quo_nxt;
          prem  <= prem_nxt;
          // Counter saturates on the final step instead of wrapping.
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            state       <= S_DONE;
            quotient    <= quo_nxt;
            remainder   <= prem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  // Model of the result registers as the last completed division left them.
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         m_z = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One division from IDLE; intr>0 pulses a competing start at that cycle of the run.
  task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input int intr);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, lat;
    if (dvs == 0) begin
      eq = '1; er = dvd; ez = 1'b1; elat = 1;
    end else begin
      eq = dvd / dvs; er = dvd % dvs; ez = 1'b0; elat = W + 1;
    end
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_hold_q"}, quotient, m_q);
      chk({tag, "_hold_r"}, remainder, m_r);
      if (lat == intr) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    chk({tag, "_busy_done"}, busy, 1);
    m_q = eq; m_r = er; m_z = ez;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int hits, lat, exp_t;
    logic [W-1:0] a, b;

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("d100_7", 16'd100, 16'd7, 0);
    run_div("ffff_1", 16'hFFFF, 16'd1, 0);
    run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 0);
    run_div("dbz_1234", 16'h1234, 16'd0, 0);
    run_div("d9_3", 16'd9, 16'd3, 0);
    run_div("ign_5_9", 16'd5, 16'd9, 5);

    // Reset in the middle of a run
    start = 1'b1; dividend = 16'd200; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    m_q = '0; m_r = '0; m_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) hits++;
    end
    chk("mid_rst_no_done", hits, 0);
    run_div("d200_3", 16'd200, 16'd3, 0);

    // start held high: back-to-back divisions
    start = 1'b1; dividend = 16'd20; divisor = 16'd6;
    hits = 0;
    exp_t = W + 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_time", i, exp_t);
        chk("b2b_q", quotient, 3);
        chk("b2b_r", remainder, 2);
        chk("b2b_dbz", div_by_zero, 0);
        hits++;
        exp_t += W + 2;
      end
    end
    start = 1'b0;
    chk("b2b_count", hits, 2);
    lat = 0;
    while (busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_drain", busy, 0);
    m_q = 16'd3; m_r = 16'd2; m_z = 1'b0;
    @(negedge clk);

    // Random operands, with occasional zero and small divisors
    for (int n = 0; n < 24; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      run_div("rand", a, b, (n % 3 == 0) ? int'($urandom_range(1, 15)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
